resample_scheduler: RTL and testbench
=====================================

# resample_scheduler

Control block for the 16-stream polyphase L/M resampling filter (L=160, M=147). It walks the active streams round-robin and, for each output sample, computes the polyphase coefficient phase and decides whether the stream must first shift in a new input sample. It then issues one command at a time to the filter datapath and waits for completion. It sits between the system run control and the filter MAC datapath, replacing ad-hoc index arithmetic inside the datapath.

## Interface
- L, 160, interpolation factor (phase modulus)
- M, 147, decimation factor; must satisfy 0 < M < L
- L_LOG, 8, width of phase values (ceil log2 L)
- NR_STREAMS, 16, number of independent streams
- NR_STREAMS_LOG, 4, stream id width
- WD_CYCLES, 1024, watchdog timeout; used only with watchdog compiled in
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- en  in  1  run enable
- stream_mask  in  NR_STREAMS  bit s=1 means stream s is active
- cmd_valid  out  1  command offered to datapath
- cmd_ready  in  1  datapath accepts command
- cmd_stream  out  NR_STREAMS_LOG  stream id of command
- cmd_phase  out  L_LOG  coefficient phase p; datapath taps are p, p+L, p+2L, p+3L
- cmd_shift  out  1  datapath must shift in one new input sample before the MAC
- done  in  1  one-cycle pulse: outstanding command finished
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog error

## Operation
- Per-stream state: phase[s] (L_LOG bits, reset 0) and pend_shift[s] (reset 1, so the first output of every stream fetches a sample).
- FSM states: IDLE, SELECT, ISSUE, WAIT.
- IDLE: goes to SELECT when en=1.
- SELECT, 1 cycle: the round-robin pick searches for the next set stream_mask bit after last_stream, wrapping from NR_STREAMS-1 to 0. After reset last_stream=NR_STREAMS-1, so stream 0 is searched first. Found stream: latch it and go to ISSUE. Mask all zero: go to IDLE.
- ISSUE: cmd_valid=1. cmd_stream, cmd_phase=phase[s] and cmd_shift=pend_shift[s] are held stable until acceptance.
- On acceptance (cmd_valid & cmd_ready):
  - sum = phase[s] + M, computed L_LOG+1 bits wide
  - if sum >= L: phase[s] = sum - L and pend_shift[s] = 1; otherwise phase[s] = sum and pend_shift[s] = 0
  - last_stream = s; go to WAIT
- WAIT: on done, go to SELECT if en=1, else IDLE. done is ignored in every other state, including the acceptance cycle.
- en=0 never aborts a command. An offered command stays offered; the outstanding command completes.
- stream_mask is sampled only in SELECT. Masked streams keep their phase and pend_shift state.
- Over any L consecutive commands to one stream, exactly M have cmd_shift=1.

## Timing
- Reset values: cmd_valid=0, cmd_stream=0, cmd_phase=0, cmd_shift=0, busy=0, err=0. State returns to IDLE and all phase/pend_shift/last_stream are reinitialised. Reset may be asserted at any time, including mid-command.
- cmd_valid asserts two cycles after en rises from IDLE (IDLE→SELECT→ISSUE).
- Minimum command period is 3 cycles: SELECT, ISSUE with ready already high, WAIT with done in the first cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- RESAMP_SCHED_WATCHDOG_EN defined:
  - A counter runs in WAIT.
  - If done has not arrived after WD_CYCLES cycles, err is set (sticky until reset), the command is abandoned with its phase update kept, and the FSM goes to SELECT/IDLE as for done.
- Not defined: no counter; err is tied 0; WAIT waits indefinitely.

## Structure
- Package resamp_pkg holds L, M, L_LOG, NR_STREAMS, NR_STREAMS_LOG and the FSM state encoding. The filter datapath shares the same package.
- One sub-module, rr_arbiter: combinational next-active-stream search given the mask and last_stream. It outputs found and the selected index.

## Test plan
- Single stream, mask=0x0001, ready and done always prompt: first four commands are (phase, shift) = (0,1), (147,0), (134,1), (121,1). The 161st command returns to phase 0 with shift=1.
- Over 160 commands on one stream, exactly 147 have cmd_shift=1, and phases are a permutation of 0..159.
- mask=0x8005: stream order 0, 2, 15, 0, …; each stream's phase sequence is independent of the others.
- Hold cmd_ready=0 for 5 cycles: cmd_valid and all cmd fields stay stable, and the phase is unchanged until acceptance.
- Drop en during WAIT: done is still consumed and the FSM goes to IDLE with busy=0. Assert rst mid-WAIT: all outputs reach their reset values immediately, and the next run restarts at stream 0, phase 0, shift 1.
- With RESAMP_SCHED_WATCHDOG_EN and WD_CYCLES=8: withhold done, and err rises after 8 WAIT cycles; the next command goes to the next stream.

Source files
------------

// File: rtl/resamp_pkg.sv
// resamp_pkg: shared constants, types and FSM encoding for the 16-stream
// polyphase L/M resampler (L=160, M=147). The filter datapath uses the same
// package.
// Contents: ratio constants, stream/phase types, scheduler state encoding,
// and phase_step(), which advances one coefficient phase by M modulo L.
package resamp_pkg;

  localparam int L              = 160;
  localparam int M              = 147;
  localparam int L_LOG          = 8;
  localparam int NR_STREAMS     = 16;
  localparam int NR_STREAMS_LOG = 4;

  typedef logic [L_LOG-1:0]          phase_t;
  typedef logic [NR_STREAMS_LOG-1:0] stream_t;

  // Scheduler FSM encoding; plain constants so legacy tools can share it.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  typedef struct packed {
    phase_t phase;  // phase for the next output sample
    logic   wrap;   // phase passed L: next output needs a new input sample
  } step_t;

  // The sum needs one bit more than a phase, because phase + M can reach
  // L-1 + M, which is above 2**L_LOG - 1.
  function automatic step_t phase_step(phase_t p);
    logic [L_LOG:0] sum;
    step_t          r;
    sum     = {1'b0, p} + (L_LOG+1)'(M);
    r.wrap  = (sum >= (L_LOG+1)'(L));
    r.phase = r.wrap ? L_LOG'(sum - (L_LOG+1)'(L)) : L_LOG'(sum);
    return r;
  endfunction

endpackage

// File: rtl/resample_scheduler_if.sv
// resample_scheduler_if: command channel between the resample scheduler and
// the filter MAC datapath.
//   cmd_valid/cmd_ready : command handshake (scheduler -> datapath)
//   cmd_stream          : stream id of the command
//   cmd_phase           : coefficient phase p (taps p, p+L, p+2L, p+3L)
//   cmd_shift           : shift in one new input sample before the MAC
//   done                : one-cycle pulse from the datapath, command finished
// Modports: master = scheduler side, slave = datapath side.
interface resample_scheduler_if;
  import resamp_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  stream_t cmd_stream;
  phase_t  cmd_phase;
  logic    cmd_shift;
  logic    done;

  modport master (
    output cmd_valid, cmd_stream, cmd_phase, cmd_shift,
    input  cmd_ready, done
  );

  modport slave (
    input  cmd_valid, cmd_stream, cmd_phase, cmd_shift,
    output cmd_ready, done
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search. Returns the first set bit of
// mask strictly after last, wrapping from NR_STREAMS-1 to 0; last itself is
// the final candidate.
//   mask  : active-stream bitmap
//   last  : stream served most recently
//   found : at least one mask bit set
//   pick  : selected stream id (0 when nothing found)
module rr_arbiter
  import resamp_pkg::*;
(
  input  logic [NR_STREAMS-1:0] mask,
  input  stream_t               last,
  output logic                  found,
  output stream_t               pick
);

  stream_t cand;

  // Walk from the farthest candidate to the nearest so that the nearest set
  // bit after last is the one left standing.
  // NOTE: every always_comb output gets a default first; otherwise a path
  // that skips the assignment turns the signal into a latch.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = NR_STREAMS; i >= 1; i--) begin
      cand = stream_t'((int'(last) + i) % NR_STREAMS);
      if (mask[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/resample_scheduler.sv
// resample_scheduler: walks the active streams round-robin, computes the
// polyphase coefficient phase for each output sample, decides whether the
// stream must shift in a new input sample first, and issues one command at a
// time to the filter datapath, waiting for its done pulse.
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   en          : run enable (never aborts a command in flight)
//   stream_mask : bit s = 1 marks stream s active; sampled in SELECT only
//   cmd_bus     : command channel (master side of resample_scheduler_if)
//   busy        : high in every state except IDLE
//   err         : sticky watchdog error
// Optional feature: define RESAMP_SCHED_WATCHDOG_EN to add a WAIT watchdog
// (parameter WD_CYCLES). Without it err is tied low and WAIT waits forever.
module resample_scheduler
  import resamp_pkg::*;
#(
  parameter int WD_CYCLES = 1024
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NR_STREAMS-1:0] stream_mask,
  resample_scheduler_if.master  cmd_bus,
  output logic                  busy,
  output logic                  err
);

  logic [1:0]            state, state_next;
  stream_t               last_stream;
  phase_t                phase [NR_STREAMS];
  logic [NR_STREAMS-1:0] pend_shift;
  logic                  found;
  stream_t               pick;
  logic                  accept;
  logic                  finish;
  step_t                 step;

  rr_arbiter u_arb (
    .mask  (stream_mask),
    .last  (last_stream),
    .found (found),
    .pick  (pick)
  );

  assign accept = (state == ST_ISSUE) && cmd_bus.cmd_valid && cmd_bus.cmd_ready;
  // cmd_stream is the stream of the outstanding command while in ISSUE.
  assign step   = phase_step(phase[cmd_bus.cmd_stream]);

`ifdef RESAMP_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;

  // A done that arrives on the last allowed cycle still counts as done.
  assign timeout = (state == ST_WAIT) && !cmd_bus.done &&
                   (wd_cnt == WD_W'(WD_CYCLES - 1));
  assign finish  = cmd_bus.done || timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT && !finish) ? wd_cnt + 1'b1 : '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign finish = cmd_bus.done;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (en) state_next = ST_SELECT;
      ST_SELECT: state_next = found ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  if (accept) state_next = ST_WAIT;
      ST_WAIT:   if (finish) state_next = en ? ST_SELECT : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are loaded from state_next so every output is a flop with no
  // combinational path from an input.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      last_stream        <= stream_t'(NR_STREAMS - 1);
      // NOTE: the phase table is reset because the first output of every
      // stream must start at phase 0; this keeps it in flops, not a RAM.
      for (int s = 0; s < NR_STREAMS; s++) phase[s] <= '0;
      pend_shift         <= '1;
      cmd_bus.cmd_valid  <= 1'b0;
      cmd_bus.cmd_stream <= '0;
      cmd_bus.cmd_phase  <= '0;
      cmd_bus.cmd_shift  <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);

      if (state == ST_SELECT && found) begin
        cmd_bus.cmd_valid  <= 1'b1;
        cmd_bus.cmd_stream <= pick;
        cmd_bus.cmd_phase  <= phase[pick];
        cmd_bus.cmd_shift  <= pend_shift[pick];
      end

      if (accept) begin
        cmd_bus.cmd_valid              <= 1'b0;
        phase[cmd_bus.cmd_stream]      <= step.phase;
        pend_shift[cmd_bus.cmd_stream] <= step.wrap;
        last_stream                    <= cmd_bus.cmd_stream;
      end
    end
  end

endmodule

// File: tb/tb_resample_scheduler.sv
// tb_resample_scheduler: directed self-checking bench for resample_scheduler.
// Expected phases are hand-computed from phase' = (phase + 147) mod 160, with
// shift set on the command that follows a wrap.
// Define RESAMP_SCHED_WATCHDOG_EN to also exercise the watchdog (WD_CYCLES=8).
module tb_resample_scheduler;
  import resamp_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en  = 1'b0;
  logic [NR_STREAMS-1:0] stream_mask = '0;
  logic                  busy;
  logic                  err;

  int checks = 0;
  int errors = 0;

  resample_scheduler_if bus ();

  resample_scheduler #(.WD_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .stream_mask (stream_mask),
    .cmd_bus     (bus),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an offered command and returns its fields.
  task automatic get_cmd(output stream_t s, output phase_t p, output logic sh,
                         output logic ok);
    int n;
    n = 0;
    while (!bus.cmd_valid && n < 20) begin
      tick();
      n++;
    end
    ok = bus.cmd_valid;
    s  = bus.cmd_stream;
    p  = bus.cmd_phase;
    sh = bus.cmd_shift;
    if (!ok) check("cmd_timeout", 32'd0, 32'd1);
  endtask

  // Accepts the offered command right away and returns done on the first
  // WAIT cycle, then leaves the FSM in SELECT.
  task automatic do_cmd(output stream_t s, output phase_t p, output logic sh);
    logic ok;
    get_cmd(s, p, sh, ok);
    if (ok) begin
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      bus.done      = 1'b1;
      tick();
      bus.done      = 1'b0;
    end
  endtask

  task automatic check_cmd(input string tag, input int es, input int ep, input int esh);
    stream_t s;
    phase_t  p;
    logic    sh;
    do_cmd(s, p, sh);
    check({tag, "_stream"}, 32'(s),  32'(es));
    check({tag, "_phase"},  32'(p),  32'(ep));
    check({tag, "_shift"},  32'(sh), 32'(esh));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    stream_t s;
    phase_t  p;
    logic    sh;
    logic    ok;
    logic    stable;
    int      nshift;
    int      nseen;
    bit      seen [L];
    int      exp_p1 [4] = '{0, 147, 134, 121};
    int      exp_s1 [4] = '{1, 0, 1, 1};
    int      t_s  [10] = '{0, 2, 15, 0, 2, 15, 2, 15, 0, 2};
    int      t_p  [10] = '{0, 0, 0, 147, 147, 147, 134, 134, 134, 121};
    int      t_sh [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

    bus.cmd_ready = 1'b0;
    bus.done      = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_valid",  32'(bus.cmd_valid),  32'd0);
    check("rst_stream", 32'(bus.cmd_stream), 32'd0);
    check("rst_phase",  32'(bus.cmd_phase),  32'd0);
    check("rst_shift",  32'(bus.cmd_shift),  32'd0);
    check("rst_busy",   32'(busy),           32'd0);
    check("rst_err",    32'(err),            32'd0);
    rst = 1'b1;
    tick();

    // Start latency: IDLE -> SELECT -> ISSUE.
    stream_mask = 16'h0001;
    en = 1'b1;
    tick();
    check("lat_select_valid", 32'(bus.cmd_valid), 32'd0);
    check("lat_select_busy",  32'(busy),          32'd1);
    tick();
    check("lat_issue_valid",  32'(bus.cmd_valid), 32'd1);

    // Single stream: one full phase cycle of 160 commands.
    nshift = 0;
    for (int i = 0; i < L; i++) seen[i] = 1'b0;
    for (int k = 0; k < L; k++) begin
      do_cmd(s, p, sh);
      if (k < 4) begin
        check($sformatf("single%0d_phase", k), 32'(p),  32'(exp_p1[k]));
        check($sformatf("single%0d_shift", k), 32'(sh), 32'(exp_s1[k]));
      end
      if (sh) nshift++;
      if (int'(p) < L) seen[int'(p)] = 1'b1;
    end
    nseen = 0;
    for (int i = 0; i < L; i++) if (seen[i]) nseen++;
    check("single_shift_count", 32'(nshift), 32'd147);
    check("single_phase_perm",  32'(nseen),  32'd160);
    check_cmd("single160", 0, 0, 1);

    // Multi-stream round robin with independent phases; mask change in the
    // middle shows masked streams keep their state.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stream_mask = 16'h8005;
    for (int k = 0; k < 10; k++) begin
      check_cmd($sformatf("rr%0d", k), t_s[k], t_p[k], t_sh[k]);
      if (k == 5) stream_mask = 16'h0004;
      if (k == 6) stream_mask = 16'h8005;
    end

    // Backpressure: ready withheld for 5 cycles.
    get_cmd(s, p, sh, ok);
    check("bp_stream", 32'(s),  32'd15);
    check("bp_phase",  32'(p),  32'd121);
    check("bp_shift",  32'(sh), 32'd1);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!(bus.cmd_valid && bus.cmd_stream == s && bus.cmd_phase == p &&
            bus.cmd_shift == sh && busy)) stable = 1'b0;
    end
    check("bp_hold_stable", 32'(stable), 32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    bus.done      = 1'b1;
    tick();
    bus.done      = 1'b0;
    check_cmd("post_bp0", 0, 121, 1);
    check_cmd("post_bp1", 2, 108, 1);
    check_cmd("post_bp2", 15, 108, 1);

    // Drop en during WAIT: the command still completes, then IDLE.
    get_cmd(s, p, sh, ok);
    check("endrop_stream", 32'(s),  32'd0);
    check("endrop_phase",  32'(p),  32'd108);
    check("endrop_shift",  32'(sh), 32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    en = 1'b0;
    tick();
    tick();
    check("endrop_wait_busy",  32'(busy),          32'd1);
    check("endrop_wait_valid", 32'(bus.cmd_valid), 32'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("endrop_idle_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("endrop_idle_valid", 32'(bus.cmd_valid), 32'd0);
    check("endrop_idle_busy2", 32'(busy),          32'd0);

    // Reset in the middle of WAIT.
    en = 1'b1;
    get_cmd(s, p, sh, ok);
    check("midrst_cmd_stream", 32'(s),  32'd2);
    check("midrst_cmd_phase",  32'(p),  32'd95);
    check("midrst_cmd_shift",  32'(sh), 32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid",  32'(bus.cmd_valid),  32'd0);
    check("midrst_stream", 32'(bus.cmd_stream), 32'd0);
    check("midrst_phase",  32'(bus.cmd_phase),  32'd0);
    check("midrst_shift",  32'(bus.cmd_shift),  32'd0);
    check("midrst_busy",   32'(busy),           32'd0);
    tick();
    rst = 1'b1;
    check_cmd("restart0", 0, 0, 1);
    check_cmd("restart1", 2, 0, 1);

`ifdef RESAMP_SCHED_WATCHDOG_EN
    // Watchdog: done withheld, err after 8 WAIT cycles, then next stream.
    get_cmd(s, p, sh, ok);
    check("wd_cmd_stream", 32'(s), 32'd15);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    repeat (7) tick();
    check("wd_err_before", 32'(err),  32'd0);
    check("wd_busy_wait",  32'(busy), 32'd1);
    tick();
    check("wd_err_after",  32'(err),  32'd1);
    check_cmd("wd_next", 0, 147, 0);
    check("wd_err_sticky", 32'(err), 32'd1);
`else
    check("no_wd_err", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
